// File: rtl/alu_muldiv_if.sv
// Request/response channel between the EX stage and the iterative multiply/divide unit.
interface alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on unsigned
// magnitudes, with sign fix-up and RISC-V special-case results applied in a final cycle.
module alu_muldiv_iter #(
    parameter int XLEN      = 32,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_r, next_s;
    logic [CW-1:0]     cnt_r;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   a_r, b_r, ma_r, mb_r, result_r;
    logic [2*XLEN-1:0] acc_r;
    logic              neg_r, rsign_r, in_ready_r, out_valid_r, busy_r;

    logic              accept_s, is_div_s, signed_a_s, signed_b_s, neg_a_s, neg_b_s;
    logic              div_zero_s, ovf_s, fast_s, q_bit_s;
    logic [XLEN-1:0]   abs_a_s, abs_b_s, div_rem_s, quot_s, remv_s, fix_result_s;
    logic [XLEN:0]     trial_s;
    logic [2*XLEN-1:0] mul_acc_s, div_acc_s, prod_s;

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = result_r;
    assign bus.busy       = busy_r;

    // Operation decode, operand magnitudes and special-case detection on the registered request
    always_comb begin
        accept_s   = bus.in_valid & in_ready_r & ~flush;
        is_div_s   = op_r[2];
        signed_a_s = (op_r == 3'd1) | (op_r == 3'd2) | (op_r == 3'd4) | (op_r == 3'd6);
        signed_b_s = (op_r == 3'd1) | (op_r == 3'd4) | (op_r == 3'd6);
        neg_a_s    = signed_a_s & a_r[XLEN-1];
        neg_b_s    = signed_b_s & b_r[XLEN-1];
        abs_a_s    = neg_a_s ? (~a_r + ONE_X) : a_r;
        abs_b_s    = neg_b_s ? (~b_r + ONE_X) : b_r;
        div_zero_s = is_div_s & (b_r == {XLEN{1'b0}});
        ovf_s      = is_div_s & ~op_r[0] & (a_r == MIN_VAL) & (b_r == ONES);
        fast_s     = ZERO_SKIP & (div_zero_s | ovf_s);
    end

    // One iteration step of each datapath plus the final sign correction and result select
    always_comb begin
        mul_acc_s = {acc_r[2*XLEN-2:0], 1'b0}
                  + (mb_r[cnt_r] ? {{XLEN{1'b0}}, ma_r} : {(2*XLEN){1'b0}});
        // High half of acc holds the partial remainder, low half shifts in quotient bits
        trial_s   = {acc_r[2*XLEN-1:XLEN], ma_r[cnt_r]};
        q_bit_s   = (trial_s >= {1'b0, mb_r});
        div_rem_s = q_bit_s ? (trial_s[XLEN-1:0] - mb_r) : trial_s[XLEN-1:0];
        div_acc_s = {div_rem_s, acc_r[XLEN-2:0], q_bit_s};
        prod_s    = neg_r ? (~acc_r + ONE_2X) : acc_r;
        quot_s    = neg_r ? (~acc_r[XLEN-1:0] + ONE_X) : acc_r[XLEN-1:0];
        remv_s    = rsign_r ? (~acc_r[2*XLEN-1:XLEN] + ONE_X) : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            3'd0:             fix_result_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_result_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: begin
                if (div_zero_s) begin
                    fix_result_s = ONES;
                end else if (ovf_s) begin
                    fix_result_s = MIN_VAL;
                end else begin
                    fix_result_s = quot_s;
                end
            end
            default: begin
                if (div_zero_s) begin
                    fix_result_s = a_r;
                end else if (ovf_s) begin
                    fix_result_s = {XLEN{1'b0}};
                end else begin
                    fix_result_s = remv_s;
                end
            end
        endcase
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_s = PREP;
                end else begin
                    next_s = IDLE;
                end
            end
            PREP: begin
                if (fast_s) begin
                    next_s = FIX;
                end else begin
                    next_s = CALC;
                end
            end
            CALC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_s = FIX;
                end else begin
                    next_s = CALC;
                end
            end
            FIX:  next_s = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = DONE;
                end
            end
            default: next_s = IDLE;
        endcase
        if (flush) begin
            next_s = IDLE;
        end else begin
            next_s = next_s;
        end
    end

    // State register and handshake outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_s;
            in_ready_r  <= (next_s == IDLE);
            out_valid_r <= (next_s == DONE);
            busy_r      <= (next_s != IDLE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= 3'd0;
            a_r      <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            ma_r     <= {XLEN{1'b0}};
            mb_r     <= {XLEN{1'b0}};
            neg_r    <= 1'b0;
            rsign_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            result_r <= {XLEN{1'b0}};
        end else if (!flush) begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r <= bus.in_op;
                        a_r  <= bus.in_a;
                        b_r  <= bus.in_b;
                    end
                end
                PREP: begin
                    ma_r    <= abs_a_s;
                    mb_r    <= abs_b_s;
                    neg_r   <= neg_a_s ^ neg_b_s;
                    rsign_r <= neg_a_s;
                    cnt_r   <= CW'(XLEN-1);
                    acc_r   <= {(2*XLEN){1'b0}};
                end
                CALC: begin
                    acc_r <= is_div_s ? div_acc_s : mul_acc_s;
                    cnt_r <= cnt_r - CW'(1);
                end
                FIX:     result_r <= fix_result_s;
                default: result_r <= result_r;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Scoreboard bench for alu_muldiv_iter: three instances (32-bit fast path, 32-bit no fast path,
// 16-bit fast path) checked against an arithmetic reference model, including latency.
module tb_alu_muldiv_iter;
    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    bit          rand_rdy = 1'b0;

    logic        iv_d [3];
    logic [2:0]  op_d [3];
    logic [31:0] a_d [3];
    logic [31:0] b_d [3];
    logic        hold_rdy [3];
    logic        ordy_d [3];
    logic        fl_d [3];
    logic        ir_m [3];
    logic        ov_m [3];
    logic        bz_m [3];
    logic [31:0] res_m [3];
    int          rise [3];
    logic        pov [3];
    sb_t         q0[$], q1[$], q2[$];
    sb_t         mon_e;

    alu_muldiv_if #(.XLEN(32)) if0 ();
    alu_muldiv_if #(.XLEN(32)) if1 ();
    alu_muldiv_if #(.XLEN(16)) if2 ();

    alu_muldiv_iter #(.XLEN(32), .ZERO_SKIP(1'b1)) dut0 (.clk(clk), .rst(rst), .flush(fl_d[0]), .bus(if0.slave));
    alu_muldiv_iter #(.XLEN(32), .ZERO_SKIP(1'b0)) dut1 (.clk(clk), .rst(rst), .flush(fl_d[1]), .bus(if1.slave));
    alu_muldiv_iter #(.XLEN(16), .ZERO_SKIP(1'b1)) dut2 (.clk(clk), .rst(rst), .flush(fl_d[2]), .bus(if2.slave));

    assign if0.in_valid = iv_d[0];  assign if0.in_op = op_d[0];
    assign if0.in_a = a_d[0];       assign if0.in_b = b_d[0];  assign if0.out_ready = ordy_d[0];
    assign if1.in_valid = iv_d[1];  assign if1.in_op = op_d[1];
    assign if1.in_a = a_d[1];       assign if1.in_b = b_d[1];  assign if1.out_ready = ordy_d[1];
    assign if2.in_valid = iv_d[2];  assign if2.in_op = op_d[2];
    assign if2.in_a = a_d[2][15:0]; assign if2.in_b = b_d[2][15:0]; assign if2.out_ready = ordy_d[2];
    assign ir_m[0] = if0.in_ready;  assign ov_m[0] = if0.out_valid; assign bz_m[0] = if0.busy;
    assign ir_m[1] = if1.in_ready;  assign ov_m[1] = if1.out_valid; assign bz_m[1] = if1.busy;
    assign ir_m[2] = if2.in_ready;  assign ov_m[2] = if2.out_valid; assign bz_m[2] = if2.busy;
    assign res_m[0] = if0.out_result;
    assign res_m[1] = if1.out_result;
    assign res_m[2] = {16'd0, if2.out_result};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready changes just after the rising edge so the monitor sees a settled value
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 3; d++) begin
            ordy_d[d] = rand_rdy ? ($urandom_range(0, 3) != 0) : hold_rdy[d];
        end
    end

    function automatic int xl(input int d);
        return (d == 2) ? 16 : 32;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int w);
        longint mk, mn, ua, ub, sa, sb, r;
        logic signed [127:0] pa, pb, p;
        mk = (longint'(1) << w) - 1;
        mn = longint'(1) << (w - 1);
        ua = longint'(a) & mk;
        ub = longint'(b) & mk;
        sa = (ua >= mn) ? ua - (mk + 1) : ua;
        sb = (ub >= mn) ? ub - (mk + 1) : ub;
        if (!op[2]) begin
            pa = (op == 3'd3) ? ua : sa;
            pb = (op == 3'd0 || op == 3'd1) ? sb : ub;
            p  = pa * pb;
            r  = (op == 3'd0) ? longint'(p) : longint'(p >>> w);
        end else if (ub == 0) begin
            r = op[1] ? ua : mk;
        end else if (!op[0] && sa == -mn && sb == -1) begin
            r = op[1] ? 0 : mn;
        end else if (!op[0]) begin
            r = op[1] ? (sa % sb) : (sa / sb);
        end else begin
            r = op[1] ? (ua % ub) : (ua / ub);
        end
        return 32'(r & mk);
    endfunction

    function automatic int exp_lat(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint mk, mn, ua, ub;
        bit zs, fast;
        mk = (longint'(1) << xl(d)) - 1;
        mn = longint'(1) << (xl(d) - 1);
        ua = longint'(a) & mk;
        ub = longint'(b) & mk;
        zs = (d != 1);
        fast = zs && op[2] && (ub == 0 || (!op[0] && ua == mn && ub == mk));
        return fast ? 2 : xl(d) + 2;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mk, v;
        mk = (w == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = mk;
            3:       v = (mk >> 1) + 32'd1;
            4:       v = mk >> 1;
            5:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v & mk;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit pop(input int d, output sb_t e);
        bit got = 1'b0;
        case (d)
            0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        return got;
    endfunction

    // Monitor: every output handshake pops the oldest expectation for that instance
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov_m[d] === 1'b1 && pov[d] !== 1'b1) rise[d] = cyc;
            pov[d] = ov_m[d];
            if (ov_m[d] === 1'b1 && ordy_d[d] === 1'b1 && fl_d[d] !== 1'b1) begin
                if (!pop(d, mon_e)) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_out dut%0d: got 0x%0h, expected no output", d, res_m[d]);
                end else begin
                    chk($sformatf("result dut%0d", d), 64'(res_m[d]), 64'(mon_e.res));
                    chk($sformatf("latency dut%0d", d), 64'(rise[d] - mon_e.acc), 64'(mon_e.lat));
                end
            end
        end
    end

    task automatic send(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push, output int acc_o);
        int t = 0;
        sb_t e;
        e.res = exp;
        e.lat = exp_lat(d, op, a, b);
        @(negedge clk);
        op_d[d] = op; a_d[d] = a; b_d[d] = b; iv_d[d] = 1'b1;
        while (ir_m[d] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        acc_o = cyc + 1;
        if (t >= 500) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout dut%0d: got in_ready=%b, expected 1", d, ir_m[d]);
        end else if (push) begin
            e.acc = acc_o;
            case (d)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(negedge clk);
        iv_d[d] = 1'b0;
    endtask

    task automatic run_dir(input int d);
        int acc;
        send(d, 3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, acc);
        send(d, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, acc);
        send(d, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
        send(d, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, acc);
        send(d, 3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b1, acc);
        send(d, 3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b1, acc);
        send(d, 3'd5, 32'd100,      32'd7,        32'd14,        1'b1, acc);
        send(d, 3'd7, 32'd100,      32'd7,        32'd2,         1'b1, acc);
        send(d, 3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, acc);
        send(d, 3'd7, 32'd5,        32'd0,        32'd5,         1'b1, acc);
        send(d, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, acc);
        send(d, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b1, acc);
        send(d, 3'd6, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1'b1, acc);
        send(d, 3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, acc);
    endtask

    task automatic rnd(input int d, input int n);
        int acc;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick(xl(d));
            b  = pick(xl(d));
            send(d, op, a, b, model(op, a, b, xl(d)), 1'b1, acc);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            nvec++;
            nerr++;
            $display("FAIL drain: got %0d pending results, expected 0", q0.size() + q1.size() + q2.size());
        end
    endtask

    task automatic chk_idle(input string nm, input int d, input logic [31:0] res);
        chk({nm, " in_ready"}, 64'(ir_m[d]), 64'd1);
        chk({nm, " out_valid"}, 64'(ov_m[d]), 64'd0);
        chk({nm, " busy"}, 64'(bz_m[d]), 64'd0);
        chk({nm, " out_result"}, 64'(res_m[d]), 64'(res));
    endtask

    initial begin
        int acc, t;
        for (int d = 0; d < 3; d++) begin
            iv_d[d] = 1'b0; op_d[d] = 3'd0; a_d[d] = 32'd0; b_d[d] = 32'd0;
            hold_rdy[d] = 1'b1; fl_d[d] = 1'b0; pov[d] = 1'b0; rise[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) chk_idle($sformatf("reset dut%0d", d), d, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_dir(0);
        run_dir(1);
        drain();

        // Backpressure: result and in_ready frozen while out_ready is low
        hold_rdy[0] = 1'b0;
        send(0, 3'd5, 32'd100, 32'd7, 32'd14, 1'b1, acc);
        t = 0;
        while (ov_m[0] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall out_valid", 64'(ov_m[0]), 64'd1);
            chk("stall in_ready", 64'(ir_m[0]), 64'd0);
            chk("stall out_result", 64'(res_m[0]), 64'd14);
        end
        hold_rdy[0] = 1'b1;
        send(0, 3'd0, 32'd12345, 32'd678, 32'd8369910, 1'b1, acc);
        send(0, 3'd7, 32'd1000, 32'd7, 32'd6, 1'b1, acc);
        drain();

        // Flush ten cycles into a divide
        send(0, 3'd4, 32'd1000, 32'd3, 32'd0, 1'b0, acc);
        while (cyc < acc + 10) @(negedge clk);
        fl_d[0] = 1'b1;
        @(negedge clk);
        fl_d[0] = 1'b0;
        chk("flush in_ready", 64'(ir_m[0]), 64'd1);
        chk("flush out_valid", 64'(ov_m[0]), 64'd0);
        chk("flush busy", 64'(bz_m[0]), 64'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of an iteration
        send(0, 3'd6, 32'h0001_2345, 32'd7, 32'd0, 1'b0, acc);
        repeat (10) @(negedge clk);
        chk("pre-reset busy", 64'(bz_m[0]), 64'd1);
        #1 rst = 1'b1;
        #1 chk_idle("async reset", 0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        rand_rdy = 1'b1;
        fork
            rnd(0, 400);
            rnd(1, 150);
            rnd(2, 600);
        join
        rand_rdy = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
